// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem arbiter and its per-port response slots.
package dmem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE    = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF    = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD    = 2'b10;
  localparam logic [1:0] MEM_SIZE_ILLEGAL = 2'b11;

  // Widest address any dmem instance may use; the top truncates to ADDR_WIDTH.
  localparam int REQ_AW = 32;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [REQ_AW-1:0] addr;
    logic [31:0]       wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == MEM_SIZE_ILLEGAL) ||
           ((size == MEM_SIZE_HALF) && addr_lo[0]) ||
           ((size == MEM_SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_rsp_slot.sv
// Single-entry response register: load wins over drain so a same-cycle
// drain and new grant keeps valid high with fresh data.
module dmem_rsp_slot
  import dmem_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     drain,
  input  mem_rsp_t rsp_in,
  output logic     rsp_valid,
  output mem_rsp_t rsp
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp       <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp       <= rsp_in;
    end else if (drain) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-ported dmem; rejects
// misaligned/illegal accesses and captures responses into per-port slots.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port 0: core LSU
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic                  p0_unsigned,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [31:0]           p0_rdata,
  output logic                  p0_rsp_err,
  // port 1: debug/DMA
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic                  p1_unsigned,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [31:0]           p1_rdata,
  output logic                  p1_rsp_err,
  // dmem
  output logic                  mem_we,
  output logic [1:0]            mem_write_size,
  output logic [1:0]            mem_read_size,
  output logic                  mem_unsigned_extend,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
);

  localparam int NUM_PORTS = 2;

  mem_req_t [NUM_PORTS-1:0] req;
  mem_rsp_t [NUM_PORTS-1:0] rsp;
  logic     [NUM_PORTS-1:0] req_valid, rsp_ready, rsp_valid, elig, grant;
  logic                     ptr, win, err;
  mem_req_t                 wreq;
  mem_rsp_t                 rsp_in;

  assign req_valid = {p1_req_valid, p0_req_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};

  assign req[0] = '{we: p0_we, size: p0_size, uns: p0_unsigned,
                    addr: REQ_AW'(p0_addr), wdata: p0_wdata};
  assign req[1] = '{we: p1_we, size: p1_size, uns: p1_unsigned,
                    addr: REQ_AW'(p1_addr), wdata: p1_wdata};

  // Reset gates eligibility so nothing is granted (and dmem is never written)
  // while rst_n is low.
  always_comb begin
    elig  = req_valid & (~rsp_valid | rsp_ready) & {NUM_PORTS{rst_n}};
    grant = elig;
    if (&elig) grant = ptr ? 2'b10 : 2'b01;
  end

  assign win = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (|grant)  ptr <= ~win;
  end

  always_comb begin
    wreq = '0;
    if (|grant) wreq = req[win];
  end

  assign err                 = (|grant) && misaligned(wreq.size, wreq.addr[1:0]);
  assign mem_we              = wreq.we && !err;
  assign mem_write_size      = wreq.size;
  assign mem_read_size       = wreq.size;
  assign mem_unsigned_extend = wreq.uns;
  assign mem_addr            = wreq.addr[ADDR_WIDTH-1:0];
  assign mem_wd              = wreq.wdata;

  assign rsp_in.rdata = (wreq.we || err) ? 32'h0 : mem_rd;
  assign rsp_in.err   = err;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_slot
    dmem_rsp_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (grant[n]),
      .drain     (rsp_ready[n]),
      .rsp_in    (rsp_in),
      .rsp_valid (rsp_valid[n]),
      .rsp       (rsp[n])
    );
  end

  assign p0_req_ready = grant[0];
  assign p1_req_ready = grant[1];
  assign p0_rsp_valid = rsp_valid[0];
  assign p1_rsp_valid = rsp_valid[1];
  assign p0_rdata     = rsp[0].rdata;
  assign p1_rdata     = rsp[1].rdata;
  assign p0_rsp_err   = rsp[0].err;
  assign p1_rsp_err   = rsp[1].err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed little-endian dmem model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p0_req_ready, p0_we, p0_unsigned, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic          p1_req_valid, p1_req_ready, p1_we, p1_unsigned, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [1:0]    p0_size, p1_size;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          mem_we, mem_unsigned_extend;
  logic [1:0]    mem_write_size, mem_read_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
    .p0_size(p0_size), .p0_unsigned(p0_unsigned), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rdata(p0_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
    .p1_size(p1_size), .p1_unsigned(p1_unsigned), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rdata(p1_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_we(mem_we), .mem_write_size(mem_write_size), .mem_read_size(mem_read_size),
    .mem_unsigned_extend(mem_unsigned_extend), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // dmem model: byte i seeded with i[7:0]; combinational read, posedge write
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          seeded = 1'b0;
  logic [AW-1:0] a0, a1, a2, a3;

  assign a0 = mem_addr;
  assign a1 = mem_addr + AW'(1);
  assign a2 = mem_addr + AW'(2);
  assign a3 = mem_addr + AW'(3);

  always_comb begin
    mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (mem_read_size)
      MEM_SIZE_BYTE: mem_rd = mem_unsigned_extend ? {24'h0, mem[a0]} : {{24{mem[a0][7]}}, mem[a0]};
      MEM_SIZE_HALF: mem_rd = mem_unsigned_extend ? {16'h0, mem[a1], mem[a0]}
                                                  : {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i);
      seeded <= 1'b1;
    end else if (mem_we) begin
      mem[a0] <= mem_wd[7:0];
      if (mem_write_size != MEM_SIZE_BYTE) mem[a1] <= mem_wd[15:8];
      if (mem_write_size == MEM_SIZE_WORD) begin
        mem[a2] <= mem_wd[23:16];
        mem[a3] <= mem_wd[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [1:0] sz,
                       input logic u, input logic [AW-1:0] a, input logic [31:0] wd);
    if (p == 0) begin
      p0_req_valid = v; p0_we = we; p0_size = sz; p0_unsigned = u; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req_valid = v; p1_we = we; p1_size = sz; p1_unsigned = u; p1_addr = a; p1_wdata = wd;
    end
  endtask

  localparam logic [31:0] STREAM_EXP [5] = '{32'h43424140, 32'h47464544, 32'h4B4A4948,
                                             32'h4F4E4D4C, 32'h53525150};

  initial begin
    rst_n = 1'b0;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    drive(0, 1'b1, 1'b1, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h11111111);
    drive(1, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    #2;
    chk("rst_p0_ready", 32'(p0_req_ready), 32'd0);
    chk("rst_mem_we",   32'(mem_we), 32'd0);
    tick;
    tick;
    chk("rst_p0_valid", 32'(p0_rsp_valid), 32'd0);
    chk("rst_p1_valid", 32'(p1_rsp_valid), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p0_err",   32'(p0_rsp_err), 32'd0);
    drive(0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    rst_n = 1'b1;
    tick;

    // contention: strict alternation starting with port 0
    drive(0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    drive(1, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h004, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_rdy0_%0d", i), 32'(p0_req_ready), 32'(i % 2 == 0));
      chk($sformatf("alt_rdy1_%0d", i), 32'(p1_req_ready), 32'(i % 2 == 1));
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        chk($sformatf("alt_v0_%0d", i), 32'(p0_rsp_valid), 32'd1);
        chk($sformatf("alt_d0_%0d", i), p0_rdata, 32'h03020100);
      end else begin
        chk($sformatf("alt_v1_%0d", i), 32'(p1_rsp_valid), 32'd1);
        chk($sformatf("alt_d1_%0d", i), p1_rdata, 32'h07060504);
        chk($sformatf("alt_v0clr_%0d", i), 32'(p0_rsp_valid), 32'd0);
      end
    end
    drive(0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    drive(1, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    tick;

    // port 0 alone: store then load word
    drive(0, 1'b1, 1'b1, MEM_SIZE_WORD, 1'b0, 12'h010, 32'hDEADBEEF);
    #1;
    chk("st_ready", 32'(p0_req_ready), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    tick;
    chk("st_valid", 32'(p0_rsp_valid), 32'd1);
    chk("st_rdata", p0_rdata, 32'h0);
    chk("st_err", 32'(p0_rsp_err), 32'd0);
    drive(0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h010, 32'h0);
    tick;
    chk("ld_valid", 32'(p0_rsp_valid), 32'd1);
    chk("ld_rdata", p0_rdata, 32'hDEADBEEF);
    chk("ld_err", 32'(p0_rsp_err), 32'd0);
    drive(0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    tick;
    chk("ld_drained", 32'(p0_rsp_valid), 32'd0);

    // port 1 stalls with a held response; port 0 streams 5 loads
    p1_rsp_ready = 1'b0;
    drive(1, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h004, 32'h0);
    tick;
    chk("stall_p1_valid", 32'(p1_rsp_valid), 32'd1);
    drive(1, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h008, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, AW'(12'h040 + 4 * i), 32'h0);
      #1;
      chk($sformatf("stream_rdy0_%0d", i), 32'(p0_req_ready), 32'd1);
      chk($sformatf("stream_rdy1_%0d", i), 32'(p1_req_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("stream_d0_%0d", i), p0_rdata, STREAM_EXP[i]);
      chk($sformatf("stream_v1_%0d", i), 32'(p1_rsp_valid), 32'd1);
      chk($sformatf("stream_d1_%0d", i), p1_rdata, 32'h07060504);
    end
    drive(0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    p1_rsp_ready = 1'b1;
    #1;
    chk("reload_rdy1", 32'(p1_req_ready), 32'd1);
    tick;
    chk("reload_v1", 32'(p1_rsp_valid), 32'd1);
    chk("reload_d1", p1_rdata, 32'h0B0A0908);
    drive(1, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    tick;
    chk("reload_clr1", 32'(p1_rsp_valid), 32'd0);

    // rejected accesses
    drive(0, 1'b1, 1'b0, MEM_SIZE_HALF, 1'b0, 12'h003, 32'h0);
    tick;
    chk("mis_half_err", 32'(p0_rsp_err), 32'd1);
    chk("mis_half_rdata", p0_rdata, 32'h0);
    drive(0, 1'b1, 1'b1, MEM_SIZE_WORD, 1'b0, 12'h006, 32'hAAAAAAAA);
    #1;
    chk("mis_word_we", 32'(mem_we), 32'd0);
    tick;
    chk("mis_word_err", 32'(p0_rsp_err), 32'd1);
    drive(0, 1'b1, 1'b1, MEM_SIZE_ILLEGAL, 1'b0, 12'h004, 32'hBBBBBBBB);
    #1;
    chk("illegal_we", 32'(mem_we), 32'd0);
    tick;
    chk("illegal_err", 32'(p0_rsp_err), 32'd1);
    chk("illegal_rdata", p0_rdata, 32'h0);
    drive(0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h004, 32'h0);
    tick;
    chk("unchanged_err", 32'(p0_rsp_err), 32'd0);
    chk("unchanged_rdata", p0_rdata, 32'h07060504);

    // byte store by p0, then sign/zero-extended byte loads by p1
    drive(0, 1'b1, 1'b1, MEM_SIZE_BYTE, 1'b0, 12'h021, 32'h00000080);
    tick;
    drive(0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    drive(1, 1'b1, 1'b0, MEM_SIZE_BYTE, 1'b0, 12'h021, 32'h0);
    tick;
    chk("lb_rdata", p1_rdata, 32'hFFFFFF80);
    drive(1, 1'b1, 1'b0, MEM_SIZE_BYTE, 1'b1, 12'h021, 32'h0);
    tick;
    chk("lbu_rdata", p1_rdata, 32'h00000080);
    drive(1, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    tick;

    // reset mid-transaction; pointer returns to port 0
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    drive(0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    drive(1, 1'b1, 1'b1, MEM_SIZE_WORD, 1'b0, 12'h100, 32'h12345678);
    tick;
    chk("pre_rst_v0", 32'(p0_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v0", 32'(p0_rsp_valid), 32'd0);
    chk("mid_rst_v1", 32'(p1_rsp_valid), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_rdy1", 32'(p1_req_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy0", 32'(p0_req_ready), 32'd1);
    chk("post_rst_rdy1", 32'(p1_req_ready), 32'd0);
    tick;
    chk("post_rst_v0", 32'(p0_rsp_valid), 32'd1);
    #1;
    chk("p1_store_rdy", 32'(p1_req_ready), 32'd1);
    chk("p1_store_we", 32'(mem_we), 32'd1);
    tick;
    drive(1, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    drive(0, 1'b1, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h100, 32'h0);
    p0_rsp_ready = 1'b1;
    tick;
    chk("raw_rdata", p0_rdata, 32'h12345678);
    drive(0, 1'b0, 1'b0, MEM_SIZE_WORD, 1'b0, 12'h000, 32'h0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
